// File: rtl/pkt_pkg.sv
// Shared definitions for the frame assembler and the CRC engine it feeds.
// Holds the FSM state encoding, the default delimiter, the payload length
// (tied to the 320-bit CRC engine input) and the CRC wait budget.
package pkt_pkg;

   localparam logic [7:0] SOF_BYTE_DEF      = 8'hD5;
   localparam int         PAYLOAD_BYTES_DEF = 40;
   localparam int         DATA_W            = PAYLOAD_BYTES_DEF * 8;
   localparam int         CRC_TIMEOUT_DEF   = 63;
   localparam int         CNT_W             = 16;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_PAYLOAD,
      ST_FCS,
      ST_START,
      ST_WAIT,
      ST_REPORT
   } state_t;

   // States in which the assembler takes bytes from the stream.
   function automatic logic accepts_bytes(input state_t s);
      return (s == ST_HUNT) || (s == ST_PAYLOAD) || (s == ST_FCS);
   endfunction

endpackage

// File: rtl/frame_assembler_if.sv
// Byte stream and CRC engine connection for the frame assembler.
//   byte_in/byte_valid/byte_ready : incoming stream, transfer on valid&ready
//   data_raw/crc_valid            : payload and start pulse to the CRC engine
//   crc_in/crc_done               : CRC result and completion pulse
// slave  = assembler side, master = stream source plus CRC engine side.
interface frame_assembler_if;
   import pkt_pkg::*;

   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic [DATA_W-1:0] data_raw;
   logic              crc_valid;
   logic [31:0]       crc_in;
   logic              crc_done;

   modport slave (
      input  byte_in, byte_valid, crc_in, crc_done,
      output byte_ready, data_raw, crc_valid
   );

   modport master (
      output byte_in, byte_valid, crc_in, crc_done,
      input  byte_ready, data_raw, crc_valid
   );

endinterface

// File: rtl/frame_assembler_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
//   clk, rst : clock, async active-high reset
//   inc      : count this cycle
//   count    : current value
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/frame_assembler.sv
// Frame assembler: hunts for the SOF delimiter, gathers the payload into
// data_raw, collects the 4-byte FCS (LSB byte first), kicks the CRC engine
// and reports whether the engine's CRC matches the received FCS.
//   clk, rst              : clock, async active-high reset
//   bus (slave)           : byte stream in, CRC engine request/response
//   frame_ok / frame_err  : one-cycle verdict pulses
//   timeout               : with frame_err when the engine never answered
//   ok_cnt/err_cnt/drop_cnt : saturating good/bad frame and dropped-byte counts
//
// state   | meaning
// HUNT    | waiting for SOF, other bytes dropped and counted
// PAYLOAD | storing payload bytes into data_raw
// FCS     | collecting the 4 FCS bytes
// START   | one-cycle crc_valid pulse to the engine
// WAIT    | waiting for crc_done, bounded by the timeout timer
// REPORT  | verdict pulse cycle, then back to HUNT
module frame_assembler
   import pkt_pkg::*;
#(
   parameter logic [7:0] SOF_BYTE      = SOF_BYTE_DEF,
   parameter int         PAYLOAD_BYTES = PAYLOAD_BYTES_DEF,
   parameter int         CRC_TIMEOUT   = CRC_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   frame_assembler_if.slave bus,
   output logic             frame_ok,
   output logic             frame_err,
   output logic             timeout,
   output logic [CNT_W-1:0] ok_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   localparam int IDX_W   = $clog2(PAYLOAD_BYTES);
   localparam int SLOT_W  = $clog2(DATA_W);
   localparam int TIMER_W = $clog2(CRC_TIMEOUT + 1);

   state_t             state, state_next;
   logic [IDX_W-1:0]   byte_idx;
   logic [31:0]        fcs;
   logic [TIMER_W-1:0] timer;
   logic [DATA_W-1:0]  data_raw;
   logic               byte_ready;
   logic               crc_valid;

   logic               accept, is_sof, last_payload, last_fcs;
   logic               crc_match, wait_tc, drop_inc;
   logic [SLOT_W-1:0]  slot_lo;
   logic               byte_ready_next, crc_valid_next;
   logic               frame_ok_next, frame_err_next, timeout_next;

   assign accept       = bus.byte_valid && byte_ready;
   assign is_sof       = (bus.byte_in == SOF_BYTE);
   assign last_payload = (byte_idx == IDX_W'(PAYLOAD_BYTES - 1));
   assign last_fcs     = (byte_idx == IDX_W'(3));
   assign crc_match    = (fcs == bus.crc_in);
   // Timer holds the cycles left before the report cycle; at 1 the next
   // cycle is the timeout report.
   assign wait_tc      = (timer == TIMER_W'(1));
   assign drop_inc     = (state == ST_HUNT) && accept && !is_sof;
   // Payload byte k lands at bit (PAYLOAD_BYTES-1-k)*8, so byte 0 is on top.
   assign slot_lo      = SLOT_W'((PAYLOAD_BYTES - 1 - int'(byte_idx)) * 8);

   assign bus.byte_ready = byte_ready;
   assign bus.data_raw   = data_raw;
   assign bus.crc_valid  = crc_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_HUNT;
      else     state <= state_next;
   end

   always_comb begin
      state_next     = state;
      frame_ok_next  = 1'b0;
      frame_err_next = 1'b0;
      timeout_next   = 1'b0;
      case (state)
         ST_HUNT:    if (accept && is_sof) state_next = ST_PAYLOAD;
         ST_PAYLOAD: if (accept && last_payload) state_next = ST_FCS;
         ST_FCS:     if (accept && last_fcs) state_next = ST_START;
         ST_START:   state_next = ST_WAIT;
         ST_WAIT: begin
            // A completion on the last allowed cycle still wins over timeout.
            if (bus.crc_done) begin
               state_next     = ST_REPORT;
               frame_ok_next  = crc_match;
               frame_err_next = !crc_match;
            end else if (wait_tc) begin
               state_next     = ST_REPORT;
               frame_err_next = 1'b1;
               timeout_next   = 1'b1;
            end
         end
         ST_REPORT:  state_next = ST_HUNT;
         default:    state_next = ST_HUNT;
      endcase
      // Registered from the next state so the outputs track the state itself.
      byte_ready_next = accepts_bytes(state_next);
      crc_valid_next  = (state_next == ST_START);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_ready <= 1'b0;
         crc_valid  <= 1'b0;
         frame_ok   <= 1'b0;
         frame_err  <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         byte_ready <= byte_ready_next;
         crc_valid  <= crc_valid_next;
         frame_ok   <= frame_ok_next;
         frame_err  <= frame_err_next;
         timeout    <= timeout_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx <= '0;
         fcs      <= '0;
         data_raw <= '0;
         timer    <= '0;
      end else begin
         case (state)
            ST_HUNT: begin
               if (accept && is_sof) byte_idx <= '0;
            end
            ST_PAYLOAD: begin
               if (accept) begin
                  data_raw[slot_lo +: 8] <= bus.byte_in;
                  byte_idx <= last_payload ? '0 : byte_idx + IDX_W'(1);
               end
            end
            ST_FCS: begin
               if (accept) begin
                  fcs[{byte_idx[1:0], 3'b000} +: 8] <= bus.byte_in;
                  byte_idx <= last_fcs ? '0 : byte_idx + IDX_W'(1);
               end
            end
            ST_START: timer <= TIMER_W'(CRC_TIMEOUT - 1);
            ST_WAIT:  timer <= timer - TIMER_W'(1);
            default: ;
         endcase
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_ok_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (frame_ok),
      .count (ok_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (frame_err),
      .count (err_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (drop_inc),
      .count (drop_cnt)
   );

endmodule
